// File: rtl/alu_cmd_sequencer.sv
// Command FIFO and issue stage in front of the 8-bit registered ALU.
// Each result is captured two edges after issue and returned tagged with its opcode.
`timescale 1ns/1ps
module alu_cmd_sequencer #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [3:0]    cmd_op,
  input  logic [7:0]    cmd_a,
  input  logic [7:0]    cmd_b,
  input  logic          halt,
  output logic [7:0]    alu_in1,
  output logic [7:0]    alu_in2,
  output logic [3:0]    alu_op,
  input  logic [7:0]    alu_out,
  output logic          res_valid,
  output logic [7:0]    res_data,
  output logic [3:0]    res_op,
  output logic [AW:0]   fifo_count,
  output logic [15:0]   issue_cnt
);

  localparam logic [3:0]  OP_HOLD  = 4'd15;
  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

  logic [3:0]    r_mem_op [DEPTH];
  logic [7:0]    r_mem_a  [DEPTH];
  logic [7:0]    r_mem_b  [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;

  logic          w_push;
  logic          w_pop;

  logic [7:0]    r_alu_in1;
  logic [7:0]    r_alu_in2;
  logic [3:0]    r_alu_op;
  logic [15:0]   r_issue_cnt;

  logic          r_vld_p1;
  logic [3:0]    r_op_p1;
  logic          r_vld_p2;
  logic [3:0]    r_op_p2;

  logic          r_res_valid;
  logic [7:0]    r_res_data;
  logic [3:0]    r_res_op;

  // Ready depends only on the registered count, so a full FIFO refuses a push
  // even when the head is popped on the same edge.
  assign w_push = cmd_valid && (r_count != CNT_FULL);
  assign w_pop  = (r_count != '0) && !halt;

  // Command storage (data only, no reset)
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_op[r_wr_ptr] <= cmd_op;
      r_mem_a[r_wr_ptr]  <= cmd_a;
      r_mem_b[r_wr_ptr]  <= cmd_b;
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Stage p1: issue to the ALU; operands hold while op idles at hold
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_alu_in1   <= '0;
      r_alu_in2   <= '0;
      r_alu_op    <= OP_HOLD;
      r_vld_p1    <= 1'b0;
      r_issue_cnt <= '0;
    end else begin
      r_vld_p1 <= w_pop;
      if (w_pop) begin
        r_alu_in1   <= r_mem_a[r_rd_ptr];
        r_alu_in2   <= r_mem_b[r_rd_ptr];
        r_alu_op    <= r_mem_op[r_rd_ptr];
        r_issue_cnt <= r_issue_cnt + 16'd1;
      end else begin
        r_alu_op    <= OP_HOLD;
      end
    end
  end

  // Opcode tags travel without reset; the valid flags decide whether they matter
  always_ff @(posedge clk) begin
    if (w_pop) r_op_p1 <= r_mem_op[r_rd_ptr];
    r_op_p2 <= r_op_p1;
  end

  // Stage p2 mirrors the ALU output register; result capture follows it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld_p2    <= 1'b0;
      r_res_valid <= 1'b0;
      r_res_data  <= '0;
      r_res_op    <= '0;
    end else begin
      r_vld_p2    <= r_vld_p1;
      r_res_valid <= r_vld_p2;
      if (r_vld_p2) begin
        r_res_data <= alu_out;
        r_res_op   <= r_op_p2;
      end
    end
  end

  assign cmd_ready  = (r_count != CNT_FULL);
  assign alu_in1    = r_alu_in1;
  assign alu_in2    = r_alu_in2;
  assign alu_op     = r_alu_op;
  assign res_valid  = r_res_valid;
  assign res_data   = r_res_data;
  assign res_op     = r_res_op;
  assign fifo_count = r_count;
  assign issue_cnt  = r_issue_cnt;

endmodule

// File: doc/alu_cmd_sequencer.md
Name: alu_cmd_sequencer

Overview:
- Upstream command stage for the 8-bit registered ALU.
- Accepts ALU commands (op, operand A, operand B) over a valid/ready handshake and buffers them in a small FIFO.
- Issues one command per clock to the ALU's in1/in2/op inputs. Drives the hold opcode (15) whenever nothing is issued, so the ALU's accumulated out is preserved.
- Captures the ALU result on the cycle it becomes valid and returns it with its opcode tag.

Parameters:
DEPTH, 4, command FIFO entries; power of two, 2..16
AW, 2, FIFO pointer width; must equal log2(DEPTH)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
cmd_valid  input  1  command offered
cmd_ready  output  1  FIFO can accept a command
cmd_op  input  4  ALU opcode 0..15
cmd_a  input  8  operand for ALU in1
cmd_b  input  8  operand for ALU in2
halt  input  1  suspend issue; FIFO still accepts commands
alu_in1  output  8  to ALU in1
alu_in2  output  8  to ALU in2
alu_op  output  4  to ALU op
alu_out  input  8  from ALU out
res_valid  output  1  one-cycle pulse, result available
res_data  output  8  captured ALU result
res_op  output  4  opcode that produced res_data
fifo_count  output  AW+1  entries currently buffered
issue_cnt  output  16  commands issued, wraps 0xFFFF->0

Behaviour:
- Reset (rst_n low, asynchronous, takes effect immediately):
  - FIFO pointers and count = 0.
  - alu_in1 = 0, alu_in2 = 0, alu_op = 15.
  - res_valid = 0, res_data = 0, res_op = 0.
  - issue_cnt = 0; all pipeline valid flags = 0.
  - Commands in flight at reset are discarded; no res_valid is produced for them after reset releases.
- Handshake:
  - cmd_ready = (fifo_count != DEPTH). It is registered-state derived and does not depend on same-cycle issue.
  - A push occurs at a rising edge with cmd_valid & cmd_ready.
  - cmd_* are sampled only on a push.
- Issue stage:
  - Condition: fifo_count != 0 and halt == 0 at a rising edge.
  - On issue: pop the head entry into alu_in1/alu_in2/alu_op, set issue-valid stage 1, increment issue_cnt.
  - Otherwise: alu_op = 15, alu_in1/alu_in2 hold their previous values, stage 1 cleared.
  - No fall-through. A command pushed at edge e0 issues at e1 at the earliest.
- Simultaneous push and pop: fifo_count is unchanged and both pointers advance. When full, push is blocked even if a pop occurs in the same cycle.
- Result pipeline:
  - Stage 1 registers the issued op. Stage 2 tracks the ALU register.
  - At the edge after the ALU samples (issue edge + 2), capture alu_out into res_data and the tag into res_op, and pulse res_valid for one cycle.
  - Latency: push at e0 -> issue at e1 -> ALU registers at e2 -> res_valid high after e3.
  - Back-to-back issues give back-to-back res_valid pulses with no gaps.
- Opcodes 8..14 operate on the ALU's prior out. The sequencer forwards them unchanged; ordering is strictly FIFO order.
- Opcode 15 may be pushed explicitly. It is issued, counted and reported: res_data = the held ALU value.
- halt raised mid-stream:
  - Commands already issued still complete their res_valid.
  - The head command remains in the FIFO.
  - Issue resumes the edge after halt falls.
- Pointers wrap modulo DEPTH. fifo_count ranges 0..DEPTH.
- Illegal DEPTH/AW combinations are not supported.

Test Plan:
- Single command: push op=0, a=3, b=5 at e0 -> alu_op=0, alu_in1=3, alu_in2=5 after e1; res_valid pulse after e3 with res_data=8, res_op=0; issue_cnt=1.
- Chain: push {0,0x0F,0x01}, {8,x,x}, {12,x,x} consecutively.
  - Results: 0x10, then 0x20, then 0x40.
  - Three consecutive res_valid pulses; alu_op=15 afterwards.
- Full FIFO: halt=1, push 5 commands with DEPTH=4.
  - cmd_ready drops after the 4th accept; fifo_count=4; 5th command held.
  - Release halt: 4 issues, then the 5th is accepted the cycle after the first pop; results return in order.
- Simultaneous push/pop at fifo_count=2: count stays 2, order preserved.
  - Subtract {1,0x05,0x07} gives res_data=0xFE (wraps).
- Reset mid-operation: assert rst_n low for 1 cycle with 2 commands in flight and 2 buffered.
  - Immediately: alu_op=15, fifo_count=0, cmd_ready=1.
  - No res_valid pulses follow.
- issue_cnt wrap: preload 0xFFFF issues (or force) -> next issue gives issue_cnt=0x0000.
